// File: rtl/sink_ram_arbiter_if.sv
// sink_ram_arbiter_if
//   Bundles the two command/response requester ports and the AXI4-Stream
//   dump output of sink_ram_arbiter.
//   r0_* / r1_* : command valid/ready/op/addr/wdata in, one-cycle response out
//   m_axis_*    : dump stream (tdata/tvalid/tlast out, tready in)
//   Modport slave is the arbiter side; modport master is the requester /
//   stream-consumer side.
interface sink_ram_arbiter_if #(
    parameter int AW = 5,
    parameter int DW = 8
);
    logic          r0_valid;
    logic          r0_ready;
    logic [1:0]    r0_op;
    logic [AW-1:0] r0_addr;
    logic [DW-1:0] r0_wdata;
    logic          r0_rsp_valid;
    logic [DW-1:0] r0_rsp_rdata;
    logic          r0_rsp_err;

    logic          r1_valid;
    logic          r1_ready;
    logic [1:0]    r1_op;
    logic [AW-1:0] r1_addr;
    logic [DW-1:0] r1_wdata;
    logic          r1_rsp_valid;
    logic [DW-1:0] r1_rsp_rdata;
    logic          r1_rsp_err;

    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tlast;
    logic          m_axis_tready;

    modport slave (
        input  r0_valid, r0_op, r0_addr, r0_wdata,
        output r0_ready, r0_rsp_valid, r0_rsp_rdata, r0_rsp_err,
        input  r1_valid, r1_op, r1_addr, r1_wdata,
        output r1_ready, r1_rsp_valid, r1_rsp_rdata, r1_rsp_err,
        output m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        input  m_axis_tready
    );

    modport master (
        output r0_valid, r0_op, r0_addr, r0_wdata,
        input  r0_ready, r0_rsp_valid, r0_rsp_rdata, r0_rsp_err,
        output r1_valid, r1_op, r1_addr, r1_wdata,
        input  r1_ready, r1_rsp_valid, r1_rsp_rdata, r1_rsp_err,
        input  m_axis_tdata, m_axis_tvalid, m_axis_tlast,
        output m_axis_tready
    );
endinterface

// File: rtl/sink_ram_arbiter.sv
// sink_ram_arbiter
//   Owns a DEPTH x DW scratch RAM shared by two requesters under round-robin
//   arbitration. Ops: 00 read, 01 write, 10 full-RAM dump over AXI4-Stream,
//   11 illegal (error response). Responses go only to the issuing requester.
//   Ports:
//     clk   : clock, rising edge
//     reset : synchronous, active-high
//     bus   : sink_ram_arbiter_if.slave (both requesters + m_axis dump stream)

// Per-requester response register: one-cycle pulse with error flag. Read data
// is taken from the shared RAM output register only on read responses so the
// bus shows 0 for every other response and while idle.
module sink_ram_arbiter_rsp #(
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          set_vld,
    input  logic          set_err,
    input  logic          set_rd,
    input  logic [DW-1:0] ram_q,
    output logic          rsp_valid,
    output logic          rsp_err,
    output logic [DW-1:0] rsp_rdata
);
    logic vld_q, err_q, rd_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld_q <= 1'b0;
            err_q <= 1'b0;
            rd_q  <= 1'b0;
        end else begin
            vld_q <= set_vld;
            err_q <= set_err;
            rd_q  <= set_rd;
        end
    end

    assign rsp_valid = vld_q;
    assign rsp_err   = err_q;
    assign rsp_rdata = rd_q ? ram_q : '0;
endmodule

module sink_ram_arbiter #(
    parameter int AW = 5,
    parameter int DW = 8
) (
    input logic               clk,
    input logic               reset,
    sink_ram_arbiter_if.slave bus
);
    // Two requesters: the grant index and priority pointer are single bits.
    localparam int NREQ  = 2;
    localparam int DEPTH = 1 << AW;

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_DUMP = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    typedef enum logic [1:0] {IDLE, RD, DUMP} state_t;

    state_t state;
    logic   ptr;          // requester that wins when both are valid
    logic   dump_owner;
    logic [AW-1:0] dump_addr;   // address of the beat currently presented
    logic   tvalid, tlast;

    // Requester ports gathered into packed vectors
    logic [NREQ-1:0]         req_vld, req_rdy;
    logic [NREQ-1:0][1:0]    req_op;
    logic [NREQ-1:0][AW-1:0] req_addr;
    logic [NREQ-1:0][DW-1:0] req_wdata;
    logic [NREQ-1:0]         rsp_valid, rsp_err;
    logic [NREQ-1:0][DW-1:0] rsp_rdata;

    assign req_vld   = {bus.r1_valid, bus.r0_valid};
    assign req_op    = {bus.r1_op,    bus.r0_op};
    assign req_addr  = {bus.r1_addr,  bus.r0_addr};
    assign req_wdata = {bus.r1_wdata, bus.r0_wdata};

    assign bus.r0_ready     = req_rdy[0];
    assign bus.r1_ready     = req_rdy[1];
    assign bus.r0_rsp_valid = rsp_valid[0];
    assign bus.r1_rsp_valid = rsp_valid[1];
    assign bus.r0_rsp_err   = rsp_err[0];
    assign bus.r1_rsp_err   = rsp_err[1];
    assign bus.r0_rsp_rdata = rsp_rdata[0];
    assign bus.r1_rsp_rdata = rsp_rdata[1];

    // ---------------- grant ----------------
    logic          gnt_vld, gnt_idx;
    logic [1:0]    gnt_op;
    logic [AW-1:0] gnt_addr;
    logic [DW-1:0] gnt_wdata;

    always_comb begin
        gnt_vld = !reset && (state == IDLE) && (|req_vld);
        // With both valid the pointer decides; otherwise the lone valid wins.
        gnt_idx = (&req_vld) ? ptr : req_vld[1];
        req_rdy = gnt_vld ? (NREQ'(1) << gnt_idx) : '0;
    end

    assign gnt_op    = req_op[gnt_idx];
    assign gnt_addr  = req_addr[gnt_idx];
    assign gnt_wdata = req_wdata[gnt_idx];

    // ---------------- dump stream ----------------
    logic dump_hs, dump_last, dump_done;

    assign dump_hs   = (state == DUMP) && tvalid && bus.m_axis_tready;
    assign dump_last = &dump_addr;
    assign dump_done = dump_hs && dump_last;

    // ---------------- RAM ----------------
    // One registered read port serves both single reads and dump beats.
    // ram_q only loads on a read enable, so a stalled beat holds its data.
    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ram_q;
    logic          ram_we, ram_re;
    logic [AW-1:0] ram_raddr;

    assign ram_we = gnt_vld && (gnt_op == OP_WR);

    always_comb begin
        ram_re    = 1'b0;
        ram_raddr = gnt_addr;
        if (gnt_vld && gnt_op == OP_RD) begin
            ram_re = 1'b1;
        end else if (gnt_vld && gnt_op == OP_DUMP) begin
            ram_re    = 1'b1;
            ram_raddr = '0;
        end else if (dump_hs && !dump_last) begin
            ram_re    = 1'b1;
            ram_raddr = dump_addr + 1'b1;
        end
    end

    // Contents are deliberately not reset; they survive a reset pulse.
    always_ff @(posedge clk) begin
        if (ram_we)
            mem[gnt_addr] <= gnt_wdata;
        if (ram_re)
            ram_q <= mem[ram_raddr];
    end

    assign bus.m_axis_tdata  = tvalid ? ram_q : '0;
    assign bus.m_axis_tvalid = tvalid;
    assign bus.m_axis_tlast  = tlast;

    // ---------------- control FSM ----------------
    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            ptr        <= 1'b0;
            dump_owner <= 1'b0;
            dump_addr  <= '0;
            tvalid     <= 1'b0;
            tlast      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (gnt_vld) begin
                        ptr <= ~gnt_idx;
                        case (gnt_op)
                            OP_RD:   state <= RD;
                            OP_DUMP: begin
                                state      <= DUMP;
                                dump_owner <= gnt_idx;
                                dump_addr  <= '0;
                                tvalid     <= 1'b1;
                                tlast      <= 1'b0;
                            end
                            default: state <= IDLE;   // write / illegal
                        endcase
                    end
                end
                RD: state <= IDLE;
                DUMP: begin
                    if (dump_hs) begin
                        if (dump_last) begin
                            tvalid <= 1'b0;
                            tlast  <= 1'b0;
                            state  <= IDLE;
                        end else begin
                            dump_addr <= dump_addr + 1'b1;
                            tlast     <= (dump_addr == AW'(DEPTH - 2));
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // ---------------- per-requester responses ----------------
    for (genvar i = 0; i < NREQ; i++) begin : g_rsp
        logic mine, set_vld, set_err, set_rd;

        assign mine    = gnt_vld && (gnt_idx == 1'(i));
        // Dump completion is reported when the last beat is accepted.
        assign set_vld = (mine && gnt_op != OP_DUMP) ||
                         (dump_done && dump_owner == 1'(i));
        assign set_err = mine && (gnt_op == OP_ILL);
        assign set_rd  = mine && (gnt_op == OP_RD);

        sink_ram_arbiter_rsp #(.DW(DW)) u_rsp (
            .clk       (clk),
            .reset     (reset),
            .set_vld   (set_vld),
            .set_err   (set_err),
            .set_rd    (set_rd),
            .ram_q     (ram_q),
            .rsp_valid (rsp_valid[i]),
            .rsp_err   (rsp_err[i]),
            .rsp_rdata (rsp_rdata[i])
        );
    end
endmodule

// File: tb/tb_sink_ram_arbiter.sv
module tb_sink_ram_arbiter;
    localparam int AW = 5;
    localparam int DW = 8;
    localparam int DEPTH = 1 << AW;

    localparam logic [1:0] OP_RD   = 2'b00;
    localparam logic [1:0] OP_WR   = 2'b01;
    localparam logic [1:0] OP_DUMP = 2'b10;
    localparam logic [1:0] OP_ILL  = 2'b11;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    sink_ram_arbiter_if #(.AW(AW), .DW(DW)) bus();
    sink_ram_arbiter #(.AW(AW), .DW(DW)) dut (.clk(clk), .reset(reset), .bus(bus));

    typedef struct {
        int            due;
        logic          err;
        logic [DW-1:0] rdata;
        logic          is_dump;
    } rsp_t;
    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    rsp_t  rq0[$], rq1[$];
    beat_t axq[$];
    logic [DW-1:0] model [DEPTH];
    int chk = 0, pass = 0, cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- scoreboard monitor ----------------
    logic          prev_stall = 1'b0, prev_last = 1'b0, prev_hs_last = 1'b0;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        rsp_t  e;
        beat_t b;
        logic  hs;
        if (reset) begin
            prev_stall   = 1'b0;
            prev_hs_last = 1'b0;
        end else begin
            if (bus.r0_rsp_valid) begin
                chk++;
                if (rq0.size() == 0) begin
                    $display("FAIL r0_rsp_unexpected got err=%0b rdata=%h exp none", bus.r0_rsp_err, bus.r0_rsp_rdata);
                end else begin
                    e = rq0.pop_front();
                    if (bus.r0_rsp_err !== e.err || bus.r0_rsp_rdata !== e.rdata ||
                        (e.is_dump ? !prev_hs_last : (cyc != e.due)))
                        $display("FAIL r0_rsp got err=%0b rdata=%h cyc=%0d exp err=%0b rdata=%h due=%0d dump=%0b",
                                 bus.r0_rsp_err, bus.r0_rsp_rdata, cyc, e.err, e.rdata, e.due, e.is_dump);
                    else pass++;
                end
            end
            if (bus.r1_rsp_valid) begin
                chk++;
                if (rq1.size() == 0) begin
                    $display("FAIL r1_rsp_unexpected got err=%0b rdata=%h exp none", bus.r1_rsp_err, bus.r1_rsp_rdata);
                end else begin
                    e = rq1.pop_front();
                    if (bus.r1_rsp_err !== e.err || bus.r1_rsp_rdata !== e.rdata ||
                        (e.is_dump ? !prev_hs_last : (cyc != e.due)))
                        $display("FAIL r1_rsp got err=%0b rdata=%h cyc=%0d exp err=%0b rdata=%h due=%0d dump=%0b",
                                 bus.r1_rsp_err, bus.r1_rsp_rdata, cyc, e.err, e.rdata, e.due, e.is_dump);
                    else pass++;
                end
            end
            if (prev_stall) begin
                chk++;
                if (bus.m_axis_tvalid !== 1'b1 || bus.m_axis_tdata !== prev_data || bus.m_axis_tlast !== prev_last)
                    $display("FAIL axis_hold got v=%0b d=%h l=%0b exp v=1 d=%h l=%0b",
                             bus.m_axis_tvalid, bus.m_axis_tdata, bus.m_axis_tlast, prev_data, prev_last);
                else pass++;
            end
            hs = bus.m_axis_tvalid && bus.m_axis_tready;
            if (hs) begin
                chk++;
                if (axq.size() == 0) begin
                    $display("FAIL axis_unexpected got d=%h l=%0b exp none", bus.m_axis_tdata, bus.m_axis_tlast);
                end else begin
                    b = axq.pop_front();
                    if (bus.m_axis_tdata !== b.data || bus.m_axis_tlast !== b.last)
                        $display("FAIL axis_beat got d=%h l=%0b exp d=%h l=%0b",
                                 bus.m_axis_tdata, bus.m_axis_tlast, b.data, b.last);
                    else pass++;
                end
            end
            prev_stall   = bus.m_axis_tvalid && !bus.m_axis_tready;
            prev_data    = bus.m_axis_tdata;
            prev_last    = bus.m_axis_tlast;
            prev_hs_last = hs && bus.m_axis_tlast;
        end
    end

    // ---------------- stimulus helpers ----------------
    // Called on the negedge before the accepting edge: records the expected
    // response / beats and updates the reference RAM.
    task automatic push_expect(input int r, input logic [1:0] op,
                               input logic [AW-1:0] a, input logic [DW-1:0] d);
        rsp_t  e;
        beat_t b;
        e.due = cyc + 1; e.err = 1'b0; e.rdata = '0; e.is_dump = 1'b0;
        case (op)
            OP_RD:  e.rdata = model[a];
            OP_WR:  model[a] = d;
            OP_ILL: e.err = 1'b1;
            default: begin
                e.is_dump = 1'b1;
                for (int k = 0; k < DEPTH; k++) begin
                    b.data = model[k];
                    b.last = (k == DEPTH - 1);
                    axq.push_back(b);
                end
            end
        endcase
        if (r == 0) rq0.push_back(e); else rq1.push_back(e);
    endtask

    task automatic drive_req(input int r, input logic v, input logic [1:0] op,
                             input logic [AW-1:0] a, input logic [DW-1:0] d);
        if (r == 0) begin
            bus.r0_valid = v; bus.r0_op = op; bus.r0_addr = a; bus.r0_wdata = d;
        end else begin
            bus.r1_valid = v; bus.r1_op = op; bus.r1_addr = a; bus.r1_wdata = d;
        end
    endtask

    task automatic do_cmd(input int r, input logic [1:0] op,
                          input logic [AW-1:0] a, input logic [DW-1:0] d);
        bit got = 0;
        @(posedge clk); #1;
        drive_req(r, 1'b1, op, a, d);
        for (int i = 0; i < 200 && !got; i++) begin
            @(negedge clk);
            if ((r == 0 && bus.r0_ready) || (r == 1 && bus.r1_ready)) begin
                got = 1;
                push_expect(r, op, a, d);
            end
        end
        if (!got) begin
            chk++;
            $display("FAIL accept_timeout req=%0d op=%0d got no ready exp ready", r, op);
        end
        @(posedge clk); #1;
        drive_req(r, 1'b0, OP_RD, '0, '0);
    endtask

    task automatic wait_drain(output bit ok);
        for (int i = 0; i < 1000; i++) begin
            if (rq0.size() == 0 && rq1.size() == 0 && axq.size() == 0) break;
            @(negedge clk);
        end
        ok = (rq0.size() == 0 && rq1.size() == 0 && axq.size() == 0);
        repeat (2) @(negedge clk);
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        reset = 1'b1;
        bus.m_axis_tready = 1'b1;
        drive_req(0, 1'b0, OP_RD, '0, '0);
        drive_req(1, 1'b0, OP_RD, '0, '0);
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk++;
        if ({bus.r0_rsp_valid, bus.r0_rsp_err, bus.r1_rsp_valid, bus.r1_rsp_err} !== 4'b0)
            $display("FAIL reset_rsp_flags got %b exp 0000",
                     {bus.r0_rsp_valid, bus.r0_rsp_err, bus.r1_rsp_valid, bus.r1_rsp_err});
        else pass++;
        chk++;
        if (bus.r0_rsp_rdata !== '0 || bus.r1_rsp_rdata !== '0)
            $display("FAIL reset_rsp_rdata got %h/%h exp 00/00", bus.r0_rsp_rdata, bus.r1_rsp_rdata);
        else pass++;
        chk++;
        if ({bus.m_axis_tvalid, bus.m_axis_tlast} !== 2'b00 || bus.m_axis_tdata !== '0)
            $display("FAIL reset_axis got v=%0b l=%0b d=%h exp 0 0 00",
                     bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata);
        else pass++;
        @(posedge clk); #1;
        reset = 1'b0;
    endtask

    task automatic test_write_read();
        bit ok;
        do_cmd(0, OP_WR, 5'd3, 8'hA5);
        do_cmd(0, OP_RD, 5'd3, '0);
        wait_drain(ok);
        chk++;
        if (!ok) $display("FAIL write_read_drain got pending=%0d exp 0", rq0.size() + rq1.size());
        else pass++;
    endtask

    // Write then read of the same address in consecutive grant cycles.
    task automatic test_back_to_back();
        bit ok, got = 0;
        @(posedge clk); #1;
        drive_req(0, 1'b1, OP_WR, 5'd7, 8'h3C);
        for (int i = 0; i < 50 && !got; i++) begin
            @(negedge clk);
            if (bus.r0_ready) begin got = 1; push_expect(0, OP_WR, 5'd7, 8'h3C); end
        end
        @(posedge clk); #1;
        drive_req(0, 1'b1, OP_RD, 5'd7, '0);
        @(negedge clk);
        chk++;
        if (bus.r0_ready !== 1'b1 || !got)
            $display("FAIL b2b_regrant got ready=%0b exp 1", bus.r0_ready);
        else begin
            pass++;
            push_expect(0, OP_RD, 5'd7, '0);
        end
        @(posedge clk); #1;
        drive_req(0, 1'b0, OP_RD, '0, '0);
        wait_drain(ok);
        chk++;
        if (!ok) $display("FAIL b2b_drain got pending=%0d exp 0", rq0.size());
        else pass++;
    endtask

    task automatic test_arbitration();
        bit ok;
        int n = 0, g;
        do_cmd(0, OP_WR, 5'd8, 8'h81);
        do_cmd(1, OP_WR, 5'd9, 8'h92);
        wait_drain(ok);
        @(posedge clk); #1; reset = 1'b1;          // pointer back to r0
        @(posedge clk); #1; reset = 1'b0;
        drive_req(0, 1'b1, OP_RD, 5'd8, '0);
        drive_req(1, 1'b1, OP_RD, 5'd9, '0);
        for (int t = 0; t < 60 && n < 4; t++) begin
            @(negedge clk);
            if (bus.r0_ready && bus.r1_ready) begin
                chk++;
                $display("FAIL arb_dual_ready got 11 exp one-hot");
            end else if (bus.r0_ready || bus.r1_ready) begin
                g = bus.r1_ready ? 1 : 0;
                chk++;
                if (g != (n % 2)) $display("FAIL arb_order grant%0d got r%0d exp r%0d", n, g, n % 2);
                else pass++;
                push_expect(g, OP_RD, g == 0 ? 5'd8 : 5'd9, '0);
                n++;
            end
            @(posedge clk); #1;
            if (n == 4) begin
                drive_req(0, 1'b0, OP_RD, '0, '0);
                drive_req(1, 1'b0, OP_RD, '0, '0);
            end
        end
        chk++;
        if (n != 4) $display("FAIL arb_grant_count got %0d exp 4", n);
        else pass++;
        wait_drain(ok);
        chk++;
        if (!ok) $display("FAIL arb_drain got pending=%0d exp 0", rq0.size() + rq1.size());
        else pass++;
    endtask

    task automatic test_dump_full();
        bit ok;
        for (int i = 0; i < DEPTH; i++) do_cmd(0, OP_WR, AW'(i), DW'(i + 8'h10));
        bus.m_axis_tready = 1'b1;
        do_cmd(1, OP_DUMP, '0, '0);
        wait_drain(ok);
        chk++;
        if (!ok) $display("FAIL dump_full_drain got beats_left=%0d rsp_left=%0d exp 0", axq.size(), rq1.size());
        else pass++;
        chk++;
        if (bus.m_axis_tvalid !== 1'b0) $display("FAIL dump_full_idle got tvalid=%0b exp 0", bus.m_axis_tvalid);
        else pass++;
    endtask

    task automatic test_dump_stall();
        bit ok, granted = 0;
        logic [3:0] pat = 4'b1001;      // tready sequence 1,0,0,1 (bit 0 first)
        int beats = 0, k = 0;
        bus.m_axis_tready = 1'b1;
        do_cmd(1, OP_DUMP, '0, '0);
        drive_req(0, 1'b1, OP_RD, 5'd5, '0);
        bus.m_axis_tready = pat[0];
        while (!granted && k < 400) begin
            @(negedge clk);
            chk++;
            if (beats < DEPTH) begin
                if (bus.r0_ready !== 1'b0) $display("FAIL stall_no_grant beat=%0d got ready=%0b exp 0", beats, bus.r0_ready);
                else pass++;
            end else begin
                if (bus.r0_ready !== 1'b1) $display("FAIL stall_grant_after got ready=%0b exp 1", bus.r0_ready);
                else pass++;
                push_expect(0, OP_RD, 5'd5, '0);
                granted = 1;
            end
            if (bus.m_axis_tvalid && bus.m_axis_tready) beats++;
            @(posedge clk); #1;
            if (granted || beats > DEPTH) begin
                granted = 1;
                drive_req(0, 1'b0, OP_RD, '0, '0);
            end
            k++;
            bus.m_axis_tready = pat[k % 4];
        end
        bus.m_axis_tready = 1'b1;
        wait_drain(ok);
        chk++;
        if (!ok || beats != DEPTH)
            $display("FAIL stall_drain got beats=%0d pending=%0d exp beats=%0d pending=0",
                     beats, axq.size() + rq0.size() + rq1.size(), DEPTH);
        else pass++;
    endtask

    task automatic test_illegal();
        bit ok;
        do_cmd(1, OP_ILL, 5'd4, 8'hEE);
        do_cmd(1, OP_RD, 5'd4, '0);
        wait_drain(ok);
        chk++;
        if (!ok) $display("FAIL illegal_drain got pending=%0d exp 0", rq1.size());
        else pass++;
    endtask

    task automatic test_reset_dump();
        bit ok;
        int beats = 0;
        bus.m_axis_tready = 1'b1;
        do_cmd(1, OP_DUMP, '0, '0);
        for (int i = 0; i < 100 && beats < 5; i++) begin
            @(negedge clk);
            if (bus.m_axis_tvalid && bus.m_axis_tready) beats++;
        end
        @(posedge clk); #1;
        reset = 1'b1;
        axq.delete();
        rq1.delete();
        @(posedge clk); #1;
        @(negedge clk);
        chk++;
        if (bus.m_axis_tvalid !== 1'b0 || bus.m_axis_tlast !== 1'b0 || bus.m_axis_tdata !== '0 || bus.r1_rsp_valid !== 1'b0)
            $display("FAIL reset_dump_abort got v=%0b l=%0b d=%h rsp=%0b exp 0 0 00 0",
                     bus.m_axis_tvalid, bus.m_axis_tlast, bus.m_axis_tdata, bus.r1_rsp_valid);
        else pass++;
        @(posedge clk); #1;
        reset = 1'b0;
        repeat (6) @(negedge clk);      // any response here is reported as unexpected
        do_cmd(1, OP_DUMP, '0, '0);
        wait_drain(ok);
        chk++;
        if (!ok) $display("FAIL reset_dump_restart got beats_left=%0d exp 0", axq.size());
        else pass++;
    endtask

    initial begin
        test_reset();
        test_write_read();
        test_back_to_back();
        test_arbitration();
        test_dump_full();
        test_dump_stall();
        test_illegal();
        test_reset_dump();
        $display("%0d/%0d checks passed", pass, chk);
        $finish;
    end
endmodule
